// File: rtl/mmio_ctrl.sv
// IO-region register block for the 3-stage core: cycle/instret counters, UART RX handshake
// and a small TX FIFO that decouples CPU stores from the serializer.
module mmio_ctrl #(
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    input  logic        instr_retire,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(TX_DEPTH);

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RXDATA  = 8'h04;
    localparam logic [7:0] OFF_TXDATA  = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTRET = 8'h14;
    localparam logic [7:0] OFF_CNTRST  = 8'h18;

    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tx_ovf;
    logic [31:0]      cycle_cnt;
    logic [31:0]      instret_cnt;

    logic [7:0]  offset;
    logic        sel;
    logic        rd;
    logic        wr;
    logic        tx_ready;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        cnt_clear;
    logic [31:0] rdata_next;
    logic        unused_bits;

    assign offset    = io_addr[7:0];
    assign sel       = (io_addr[31:30] == 2'b10);
    assign rd        = sel && io_re;
    assign wr        = sel && io_we;
    assign tx_ready  = (count < DEPTH);
    assign push_req  = wr && (offset == OFF_TXDATA);
    assign push      = push_req && tx_ready;
    assign pop       = uart_tx_data_in_valid && uart_tx_data_in_ready;
    assign cnt_clear = wr && (offset == OFF_CNTRST);

    assign uart_tx_data_in_valid = (count != '0);
    assign uart_tx_data_in       = fifo_mem[rd_ptr];
    assign unused_bits           = ^{io_addr[29:8], io_wdata[31:8]};

    // Load mux sees pre-update state, so reads return values from before this edge.
    always_comb begin
        rdata_next = '0;
        case (offset)
            OFF_STATUS:  rdata_next = {29'd0, tx_ovf, uart_rx_data_out_valid, tx_ready};
            OFF_RXDATA:  rdata_next = {24'd0, uart_rx_data_out};
            OFF_CYCLE:   rdata_next = cycle_cnt;
            OFF_INSTRET: rdata_next = instret_cnt;
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata               <= '0;
            uart_rx_data_out_ready <= 1'b0;
        end else begin
            if (rd) begin
                io_rdata <= rdata_next;
            end
            uart_rx_data_out_ready <= rd && (offset == OFF_RXDATA) && uart_rx_data_out_valid;
        end
    end

    // An overflowing push wins over a same-cycle STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
        end else if (push_req && !tx_ready) begin
            tx_ovf <= 1'b1;
        end else if (wr && (offset == OFF_STATUS)) begin
            tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 32'd1;
            instret_cnt <= instret_cnt + {31'd0, instr_retire};
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_mmio_ctrl;
    localparam int TX_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_wdata;
    logic        instr_retire;
    logic [31:0] io_rdata;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_cycle   = '0;
    logic [31:0] m_instret = '0;
    logic [31:0] m_rdata   = '0;
    bit          m_ovf     = 1'b0;
    bit          m_rx_rdy  = 1'b0;
    logic [7:0]  m_q[$];
    bit          started   = 1'b0;

    mmio_ctrl #(.TX_DEPTH(TX_DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .io_addr                (io_addr),
        .io_re                  (io_re),
        .io_we                  (io_we),
        .io_wdata               (io_wdata),
        .instr_retire           (instr_retire),
        .io_rdata               (io_rdata),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit re, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit retire);
        io_re        = re;
        io_we        = we;
        io_addr      = addr;
        io_wdata     = wdata;
        instr_retire = retire;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Register-level behaviour: reads see pre-edge state, FIFO is a bounded queue.
    task automatic modelStep();
        bit         sel;
        bit         rd;
        bit         wr;
        logic [7:0] off;
        int         n;
        if (rst) begin
            m_cycle   = '0;
            m_instret = '0;
            m_rdata   = '0;
            m_ovf     = 1'b0;
            m_rx_rdy  = 1'b0;
            m_q.delete();
            return;
        end
        sel = (io_addr[31:30] == 2'b10);
        off = io_addr[7:0];
        rd  = sel && io_re;
        wr  = sel && io_we;
        n   = m_q.size();
        if (rd) begin
            case (off)
                8'h00:   m_rdata = {29'd0, m_ovf, uart_rx_data_out_valid, 1'(n < TX_DEPTH)};
                8'h04:   m_rdata = {24'd0, uart_rx_data_out};
                8'h10:   m_rdata = m_cycle;
                8'h14:   m_rdata = m_instret;
                default: m_rdata = '0;
            endcase
        end
        m_rx_rdy = rd && (off == 8'h04) && uart_rx_data_out_valid;
        if (n != 0 && uart_tx_data_in_ready) begin
            void'(m_q.pop_front());
        end
        if (wr && off == 8'h08) begin
            if (n < TX_DEPTH) m_q.push_back(io_wdata[7:0]);
            else m_ovf = 1'b1;
        end else if (wr && off == 8'h00) begin
            m_ovf = 1'b0;
        end
        if (wr && off == 8'h18) begin
            m_cycle   = '0;
            m_instret = '0;
        end else begin
            m_cycle   = m_cycle + 32'd1;
            m_instret = m_instret + (instr_retire ? 32'd1 : 32'd0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
        started = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            checkOutput("model_io_rdata", io_rdata, m_rdata);
            checkOutput("model_rx_ready", {31'd0, uart_rx_data_out_ready}, {31'd0, m_rx_rdy});
            checkOutput("model_tx_valid", {31'd0, uart_tx_data_in_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
            if (m_q.size() != 0) begin
                checkOutput("model_tx_data", {24'd0, uart_tx_data_in}, {24'd0, m_q[0]});
            end
        end
    end

    initial begin
        logic [7:0] offs [8];
        logic [1:0] region;
        offs = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C};

        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        uart_tx_data_in_ready  = 1'b0;
        uart_rx_data_out       = 8'h00;
        uart_rx_data_out_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_io_rdata", io_rdata, 32'h0);
        checkOutput("reset_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
        checkOutput("reset_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h0);

        repeat (5) tick();
        applyStimulus(1, 0, 32'h8000_0010, 32'h0, 0);
        tick();
        checkOutput("cycle_after_reset_in_range",
                    (io_rdata >= 32'd4 && io_rdata <= 32'd6) ? 32'd1 : 32'd0, 32'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 32'h8000_0008, 32'h41 + 32'(i), 0);
            tick();
        end
        applyStimulus(1, 0, 32'h8000_0000, 32'h0, 0);
        tick();
        checkOutput("status_full_ovf", io_rdata, 32'h4);
        checkOutput("tx_head_first", {24'd0, uart_tx_data_in}, 32'h41);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);

        uart_tx_data_in_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_tx_data", {24'd0, uart_tx_data_in}, 32'h41 + 32'(k));
            checkOutput("drain_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h1);
            tick();
        end
        checkOutput("drain_valid_drops", {31'd0, uart_tx_data_in_valid}, 32'h0);
        uart_tx_data_in_ready = 1'b0;
        applyStimulus(0, 1, 32'h8000_0000, 32'h0, 0);
        tick();
        applyStimulus(1, 0, 32'h8000_0000, 32'h0, 0);
        tick();
        checkOutput("status_after_clear", io_rdata, 32'h1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);

        uart_rx_data_out_valid = 1'b1;
        uart_rx_data_out       = 8'h5A;
        applyStimulus(1, 0, 32'h8000_0004, 32'h0, 0);
        tick();
        checkOutput("rxdata_value", io_rdata, 32'h5A);
        checkOutput("rx_ready_pulse", {31'd0, uart_rx_data_out_ready}, 32'h1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        tick();
        checkOutput("rx_ready_single", {31'd0, uart_rx_data_out_ready}, 32'h0);

        uart_rx_data_out_valid = 1'b0;
        uart_rx_data_out       = 8'h33;
        applyStimulus(1, 0, 32'h8000_0004, 32'h0, 0);
        tick();
        checkOutput("rxdata_no_valid", io_rdata, 32'h33);
        checkOutput("rx_ready_none", {31'd0, uart_rx_data_out_ready}, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);

        force dut.cycle_cnt = 32'hFFFF_FFFF;
        m_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        applyStimulus(1, 0, 32'h8000_0010, 32'h0, 1);
        tick();
        checkOutput("cycle_max", io_rdata, 32'hFFFF_FFFF);
        tick();
        checkOutput("cycle_wrap", io_rdata, 32'h0);
        applyStimulus(0, 1, 32'h8000_0018, 32'h0, 1);
        tick();
        applyStimulus(1, 0, 32'h8000_0014, 32'h0, 0);
        tick();
        checkOutput("instret_cleared", io_rdata, 32'h0);
        applyStimulus(1, 0, 32'h8000_0010, 32'h0, 0);
        tick();
        checkOutput("cycle_after_clear", io_rdata, 32'h1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0);

        applyStimulus(0, 1, 32'h8000_0008, 32'h61, 0);
        tick();
        applyStimulus(0, 1, 32'h8000_0008, 32'h62, 0);
        tick();
        uart_tx_data_in_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) applyStimulus(0, 1, 32'h8000_0008, 32'h63 + 32'(k), 0);
            else applyStimulus(0, 0, 32'h0, 32'h0, 0);
            checkOutput("wrap_tx_data", {24'd0, uart_tx_data_in}, 32'h61 + 32'(k));
            checkOutput("wrap_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h1);
            tick();
        end
        checkOutput("wrap_valid_drops", {31'd0, uart_tx_data_in_valid}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            region = ($urandom_range(0, 9) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                          {region, 22'($urandom), offs[$urandom_range(0, 7)]},
                          $urandom, $urandom_range(0, 1) == 1);
            uart_tx_data_in_ready  = ($urandom_range(0, 2) == 0);
            uart_rx_data_out_valid = ($urandom_range(0, 1) == 1);
            uart_rx_data_out       = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        applyStimulus(0, 0, 32'h0, 32'h0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
